// File: rtl/alu_exec_unit.sv
// Handshaked single-operation ALU; shifts iterate one bit per cycle by default.
// Define ALU_EXEC_FAST_SHIFT_EN to compute shifts combinationally (latency 1, no SHIFT state).
module alu_exec_unit #(
  parameter int unsigned REG_DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      nreset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [3:0]                alu_ctrl,
  input  logic [REG_DATA_WIDTH-1:0] op_a,
  input  logic [REG_DATA_WIDTH-1:0] op_b,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [REG_DATA_WIDTH-1:0] result,
  output logic                      zero,
  output logic                      illegal
);
  localparam int unsigned ShW = $clog2(REG_DATA_WIDTH);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;
  typedef enum logic [1:0] {ShSll, ShSrl, ShSra} shift_e;

  state_e                    state_q, state_d;
  logic                      started_q;
  logic                      accept, go_shift, last_shift;
  logic                      alu_illegal, is_shift;
  shift_e                    dec_shift;
  logic [ShW-1:0]            shamt;
  logic [REG_DATA_WIDTH-1:0] alu_res, shift_step;
  logic [REG_DATA_WIDTH-1:0] result_q, result_d;
  logic                      zero_q, zero_d, illegal_q, illegal_d;
  logic [ShW-1:0]            cnt_q, cnt_d;
  shift_e                    sh_type_q, sh_type_d;

  assign shamt      = op_b[ShW-1:0];
  assign accept     = in_valid && in_ready;
  assign last_shift = (cnt_q == ShW'(1));

`ifdef ALU_EXEC_FAST_SHIFT_EN
  assign go_shift = 1'b0;
`else
  assign go_shift = is_shift && (shamt != '0);
`endif

  // Shift expressions double as the k=0 passthrough in the iterative build.
  always_comb begin
    alu_res     = '0;
    alu_illegal = 1'b0;
    is_shift    = 1'b0;
    dec_shift   = ShSll;
    case (alu_ctrl)
      4'b0000: alu_res = op_a & op_b;
      4'b0001: alu_res = op_a | op_b;
      4'b0010: alu_res = op_a + op_b;
      4'b0110: alu_res = op_a - op_b;
      4'b0111: alu_res = {{(REG_DATA_WIDTH-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      4'b1000: alu_res = {{(REG_DATA_WIDTH-1){1'b0}}, op_a < op_b};
      4'b1001: alu_res = op_a ^ op_b;
      4'b1010: begin
        is_shift  = 1'b1;
        dec_shift = ShSll;
        alu_res   = op_a << shamt;
      end
      4'b1011: begin
        is_shift  = 1'b1;
        dec_shift = ShSrl;
        alu_res   = op_a >> shamt;
      end
      4'b1100: begin
        is_shift  = 1'b1;
        dec_shift = ShSra;
        alu_res   = $signed(op_a) >>> shamt;
      end
      default: alu_illegal = 1'b1;
    endcase
  end

  always_comb begin
    case (sh_type_q)
      ShSll:   shift_step = {result_q[REG_DATA_WIDTH-2:0], 1'b0};
      ShSrl:   shift_step = {1'b0, result_q[REG_DATA_WIDTH-1:1]};
      default: shift_step = {result_q[REG_DATA_WIDTH-1], result_q[REG_DATA_WIDTH-1:1]};
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q   <= StIdle;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      started_q <= 1'b1;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (accept) state_d = go_shift ? StShift : StDone;
      StShift: if (last_shift) state_d = StDone;
      StDone:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM: outputs; started_q keeps in_ready low until the first edge out of reset
  always_comb begin
    in_ready  = (state_q == StIdle) && started_q;
    out_valid = (state_q == StDone);
  end

  always_comb begin
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    cnt_d     = cnt_q;
    sh_type_d = sh_type_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          if (go_shift) begin
            result_d  = op_a;
            cnt_d     = shamt;
            sh_type_d = dec_shift;
            illegal_d = 1'b0;
          end else begin
            result_d  = alu_res;
            zero_d    = (alu_res == '0);
            illegal_d = alu_illegal;
          end
        end
      end
      StShift: begin
        result_d = shift_step;
        cnt_d    = cnt_q - ShW'(1);
        if (last_shift) zero_d = (shift_step == '0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
      sh_type_q <= ShSll;
    end else begin
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
      sh_type_q <= sh_type_d;
    end
  end

  assign result  = result_q;
  assign zero    = zero_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: driver pushes model results, monitor pops on out_valid.
module tb_alu_exec_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         nreset = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   alu_ctrl = '0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         zero;
  logic         illegal;

  alu_exec_unit #(.REG_DATA_WIDTH(W)) dut (
    .clk       (clk),
    .nreset    (nreset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_ctrl  (alu_ctrl),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  int rdy_mode = 0;  // 0 random, 1 always ready, 2 stall

  typedef struct {
    logic [W-1:0] res;
    logic         z;
    logic         ill;
    int           lat;
    int           t0;
  } exp_t;
  exp_t sbq[$];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Reference: plain arithmetic on the opcode table; latency from the shift amount.
  function automatic void model(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] r, output logic ill, output int lat);
    int k;
    k   = int'(b[4:0]);
    ill = 1'b0;
    lat = 1;
    r   = '0;
    case (c)
      4'h0: r = a & b;
      4'h1: r = a | b;
      4'h2: r = a + b;
      4'h6: r = a - b;
      4'h7: r = ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
      4'h8: r = (a < b) ? 32'd1 : 32'd0;
      4'h9: r = a ^ b;
      4'hA: r = a << k;
      4'hB: r = a >> k;
      4'hC: r = a[W-1] ? ~((~a) >> k) : (a >> k);
      default: ill = 1'b1;
    endcase
`ifndef ALU_EXEC_FAST_SHIFT_EN
    if ((c == 4'hA || c == 4'hB || c == 4'hC) && k != 0) lat = k + 1;
`endif
  endfunction

  // Called at #1 after a rising edge; returns at #1 after the accepting edge.
  task automatic issue(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit track);
    exp_t e;
    int   n;
    n = 0;
    while (in_ready !== 1'b1 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (in_ready !== 1'b1) begin
      n_tests++;
      n_fail++;
      $display("FAIL issue_wait: in_ready=%b, required 1", in_ready);
      return;
    end
    model(c, a, b, e.res, e.ill, e.lat);
    e.z  = (e.res == '0);
    e.t0 = cyc;
    if (track) sbq.push_back(e);
    alu_ctrl = c;
    op_a     = a;
    op_b     = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    alu_ctrl = 4'($urandom);
    op_a     = $urandom;
    op_b     = $urandom;
  endtask

  // Monitor / consumer
  logic         seen = 1'b0;
  logic         hs_prev = 1'b0;
  logic [W-1:0] h_res;
  logic         h_z, h_ill;
  exp_t         me;

  always @(posedge clk) begin
    #1;
    if (nreset) begin
      if (hs_prev) begin
        check("post_hs_out_valid", W'(out_valid), W'(0));
        check("post_hs_in_ready", W'(in_ready), W'(1));
      end
      hs_prev = 1'b0;
      if (out_valid && !seen) begin
        seen  = 1'b1;
        h_res = result;
        h_z   = zero;
        h_ill = illegal;
        if (sbq.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_out_valid: result %h with no op pending", result);
        end else begin
          me = sbq.pop_front();
          check("result", result, me.res);
          check("zero", W'(zero), W'(me.z));
          check("illegal", W'(illegal), W'(me.ill));
          check("latency", W'(cyc - me.t0), W'(me.lat));
        end
      end else if (out_valid) begin
        check("held_result", result, h_res);
        check("held_flags", W'({zero, illegal}), W'({h_z, h_ill}));
        check("held_in_ready", W'(in_ready), W'(0));
      end
      case (rdy_mode)
        1:       out_ready = 1'b1;
        2:       out_ready = 1'b0;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
      if (out_valid && out_ready) begin
        hs_prev = 1'b1;
        seen    = 1'b0;
      end
    end else begin
      seen    = 1'b0;
      hs_prev = 1'b0;
    end
  end

  logic [3:0] codes [10] = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC};

  initial begin
    logic [3:0]   c;
    logic [W-1:0] a, b;
    int           ov, n;

    #12;
    check("rst_in_ready", W'(in_ready), W'(0));
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_result", result, W'(0));
    check("rst_flags", W'({zero, illegal}), W'(0));
    @(negedge clk);
    nreset = 1'b1;
    @(posedge clk); #1;
    check("first_edge_in_ready", W'(in_ready), W'(1));

    rdy_mode = 1;
    issue(4'h2, 32'hFFFF_FFFF, 32'h1, 1'b1);
    issue(4'hC, 32'h8000_0000, 32'd4, 1'b1);
    issue(4'h7, 32'hFFFF_FFFE, 32'h1, 1'b1);
    issue(4'h8, 32'hFFFF_FFFE, 32'h1, 1'b1);
    issue(4'h5, $urandom, $urandom, 1'b1);
    issue(4'hB, 32'h8000_0001, 32'd0, 1'b1);

    // Stall the consumer and watch the result hold
    rdy_mode = 2;
    issue(4'h9, 32'h1234_5678, 32'h0F0F_0F0F, 1'b1);
    repeat (3) begin @(posedge clk); #1; end
    check("stall_out_valid", W'(out_valid), W'(1));
    check("stall_in_ready", W'(in_ready), W'(0));
    rdy_mode = 1;

    // Reset mid-shift discards the operation
    issue(4'hA, 32'hDEAD_BEEF, 32'd31, 1'b0);
    repeat (5) begin @(posedge clk); #1; end
    nreset = 1'b0;
    #2;
    check("abort_in_ready", W'(in_ready), W'(0));
    check("abort_out_valid", W'(out_valid), W'(0));
    check("abort_result", result, W'(0));
    @(negedge clk);
    nreset = 1'b1;
    @(posedge clk); #1;
    check("abort_release_in_ready", W'(in_ready), W'(1));
    ov = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) ov++;
    end
    check("abort_no_out_valid", W'(ov), W'(0));
    check("abort_result_after", result, W'(0));

    rdy_mode = 0;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 3) == 0) c = 4'($urandom_range(0, 15));
      else c = codes[$urandom_range(0, 9)];
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 4) == 0) b = a;
      if ($urandom_range(0, 5) == 0) b = W'($urandom_range(0, 3));
      issue(c, a, b, 1'b1);
    end

    n = 0;
    while (sbq.size() != 0 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (sbq.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d results outstanding, required 0", sbq.size());
    end
    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 SHALL have parameter REG_DATA_WIDTH, default 32, the operand/result width (power of two, >= 8).
REQ-002 SHALL have clk  input  1  clock; all state changes on the rising edge.
REQ-003 SHALL have nreset  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have in_valid  input  1  operation request valid.
REQ-005 SHALL have in_ready  output  1  unit can accept an operation.
REQ-006 SHALL have alu_ctrl  input  4  operation code from the ALU controller stage.
REQ-007 SHALL have op_a  input  REG_DATA_WIDTH  first operand; the shift source for shifts.
REQ-008 SHALL have op_b  input  REG_DATA_WIDTH  second operand; the low log2(REG_DATA_WIDTH) bits are the shift amount for shifts.
REQ-009 SHALL have out_valid  output  1  result valid.
REQ-010 SHALL have out_ready  input  1  consumer accepts the result.
REQ-011 SHALL have result  output  REG_DATA_WIDTH  registered operation result.
REQ-012 SHALL have zero  output  1  registered flag, high when result == 0.
REQ-013 SHALL have illegal  output  1  registered flag, high when alu_ctrl was unassigned.

Function
REQ-014 SHALL decode alu_ctrl as follows: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed), 1000 SLTU, 1001 XOR, 1010 SLL, 1011 SRL, 1100 SRA.
REQ-015 SHALL produce result 0 and illegal=1 for any other alu_ctrl code, with single-op latency.
REQ-016 SHALL compute ADD/SUB modulo 2^REG_DATA_WIDTH and ignore carry and overflow; SLT/SLTU SHALL return 1 or 0 zero-extended.
REQ-017 SHALL implement the FSM states IDLE, SHIFT and DONE.
REQ-018 SHALL drive in_ready = 1 only in IDLE; an operation is accepted on an edge where in_valid && in_ready.
REQ-019 SHALL, on a non-shift accept, register result/zero/illegal and enter DONE, so out_valid rises the cycle after acceptance (latency 1).
REQ-020 SHALL, on a shift accept with shift amount k=0, enter DONE with result=op_a (latency 1).
REQ-021 SHALL, on a shift accept with k>0, latch op_a, k and the shift type, enter SHIFT, and shift one bit per cycle for k cycles, then enter DONE (out_valid after k+1 edges).
REQ-022 SHALL implement SRA by replicating the MSB of op_a, and SRL/SLL by filling with 0.
REQ-023 SHALL drive out_valid = 1 only in DONE and hold result/zero/illegal stable while out_valid && !out_ready.
REQ-024 SHALL return to IDLE on an edge where out_valid && out_ready, with in_ready high in the following cycle (no same-cycle bypass).
REQ-025 SHALL ignore in_valid, alu_ctrl, op_a and op_b outside IDLE.
REQ-026 SHALL update zero from the final result only, never from intermediate shift values.

Reset
REQ-027 SHALL, while nreset=0, force state=IDLE, result=0, zero=0, illegal=0, out_valid=0, shift counter=0, and drive in_ready=0.
REQ-028 SHALL abort any in-progress SHIFT or pending DONE on reset and discard its result.
REQ-029 SHALL raise in_ready on the first clk edge after nreset deasserts.

Configuration
REQ-030 SHALL, when the macro ALU_EXEC_FAST_SHIFT_EN is defined, compute all shifts combinationally with latency 1 and never enter SHIFT.
REQ-031 SHALL, when ALU_EXEC_FAST_SHIFT_EN is undefined, perform the iterative shift per REQ-021; all other behaviour SHALL be identical in both builds.

Verification
REQ-032 SHALL cover: ADD op_a=0xFFFFFFFF, op_b=0x1 -> out_valid 1 cycle after accept, result=0x0, zero=1.
REQ-033 SHALL cover: SRA op_a=0x80000000, op_b=4 -> iterative build out_valid 5 edges after accept, fast build 1 edge after; result=0xF8000000.
REQ-034 SHALL cover: SLT op_a=0xFFFFFFFE, op_b=0x1 -> result=1; SLTU with the same operands -> result=0.
REQ-035 SHALL cover: alu_ctrl=0101 -> result=0, illegal=1, zero=1.
REQ-036 SHALL cover: result held with out_ready=0 for 3 cycles -> result stable and in_ready=0; out_ready=1 -> in_ready=1 the next cycle.
REQ-037 SHALL cover: SLL op_b=31 with nreset pulsed low mid-SHIFT -> out_valid never asserts for that op, result=0, in_ready=1 after release.
